// File: rtl/pin_lock_controller.sv
// Purpose : PIN lock controller. Checks keypad PIN entries against a stored 4-digit BCD PIN and
//           runs the LOCKED/UNLOCKED/ADJUST/LOCKOUT state machine with lockout, auto-relock and PIN change.
// Latency : 1 cycle. All outputs are registered; an event sampled at edge N shows after edge N.
// Backpr. : none. validPin is a one-cycle pulse. kp_enable tells the keypad whether entries are accepted.
// Ports   : clk_500Hz, rst_n (async, active low) | userPin[15:0], validPin, lock_req, adjust_req in
//           status[1:0] (0 LOCKED 1 UNLOCKED 2 ADJUST 3 LOCKOUT), kp_enable, err_pulse, pin_changed,
//           attempts_left[3:0] out
module pin_lock_controller #(
    parameter logic [15:0] DEFAULT_PIN   = 16'h1234,
    parameter int unsigned MAX_ATTEMPTS  = 3,
    parameter int unsigned LOCKOUT_TICKS = 15000,
    parameter int unsigned UNLOCK_TICKS  = 5000
) (
    input  logic        clk_500Hz,
    input  logic        rst_n,
    input  logic [15:0] userPin,
    input  logic        validPin,
    input  logic        lock_req,
    input  logic        adjust_req,
    output logic [1:0]  status,
    output logic        kp_enable,
    output logic        err_pulse,
    output logic        pin_changed,
    output logic [3:0]  attempts_left
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_ADJUST   = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    typedef enum logic {
        ADJ_NEW     = 1'b0,
        ADJ_CONFIRM = 1'b1
    } adj_t;

    localparam logic [3:0]  MAX_A        = 4'(MAX_ATTEMPTS);
    localparam logic [15:0] UNLOCK_LAST  = 16'(UNLOCK_TICKS - 1);
    localparam logic [15:0] LOCKOUT_LAST = 16'(LOCKOUT_TICKS - 1);

    state_t      state_q, state_d;
    adj_t        adj_q, adj_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] stored_q, stored_d;
    logic [15:0] cand_q, cand_d;
    logic [3:0]  attempts_q, attempts_d;
    logic        err_q, err_d;
    logic        chg_q, chg_d;
    logic        kp_q, kp_d;

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOCKED;
            adj_q      <= ADJ_NEW;
            timer_q    <= '0;
            stored_q   <= DEFAULT_PIN;
            cand_q     <= '0;
            attempts_q <= MAX_A;
            err_q      <= 1'b0;
            chg_q      <= 1'b0;
            kp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            adj_q      <= adj_d;
            timer_q    <= timer_d;
            stored_q   <= stored_d;
            cand_q     <= cand_d;
            attempts_q <= attempts_d;
            err_q      <= err_d;
            chg_q      <= chg_d;
            kp_q       <= kp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        adj_d      = adj_q;
        timer_d    = timer_q;
        stored_d   = stored_q;
        cand_d     = cand_q;
        attempts_d = attempts_q;
        err_d      = 1'b0;
        chg_d      = 1'b0;

        case (state_q)
            ST_LOCKED: begin
                timer_d = '0;
                if (validPin) begin
                    if (userPin == stored_q) begin
                        state_d    = ST_UNLOCKED;
                        attempts_d = MAX_A;
                    end else begin
                        err_d = 1'b1;
                        // Last remaining attempt used: lock out and rearm the counter.
                        if (attempts_q == 4'd1) begin
                            state_d    = ST_LOCKOUT;
                            attempts_d = MAX_A;
                        end else begin
                            attempts_d = attempts_q - 4'd1;
                        end
                    end
                end
            end

            ST_UNLOCKED: begin
                timer_d = timer_q + 16'd1;
                if (lock_req) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (adjust_req) begin
                    state_d = ST_ADJUST;
                    adj_d   = ADJ_NEW;
                    timer_d = '0;
                end else if (timer_q == UNLOCK_LAST) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end
            end

            ST_ADJUST: begin
                timer_d = timer_q + 16'd1;
                if (lock_req) begin
                    state_d = ST_LOCKED;
                    adj_d   = ADJ_NEW;
                    cand_d  = '0;
                    timer_d = '0;
                end else if (validPin) begin
                    // Any entry restarts the idle window.
                    timer_d = '0;
                    if (adj_q == ADJ_NEW) begin
                        cand_d = userPin;
                        adj_d  = ADJ_CONFIRM;
                    end else if (userPin == cand_q) begin
                        stored_d = cand_q;
                        chg_d    = 1'b1;
                        state_d  = ST_UNLOCKED;
                        adj_d    = ADJ_NEW;
                    end else begin
                        err_d = 1'b1;
                        adj_d = ADJ_NEW;
                    end
                end else if (timer_q == UNLOCK_LAST) begin
                    state_d = ST_LOCKED;
                    adj_d   = ADJ_NEW;
                    timer_d = '0;
                end
            end

            default: begin // ST_LOCKOUT: all requests ignored until the timer expires
                timer_d = timer_q + 16'd1;
                if (timer_q == LOCKOUT_LAST) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end
            end
        endcase

        kp_d = (state_d == ST_LOCKED) || (state_d == ST_ADJUST);
    end

    assign status        = state_q;
    assign kp_enable     = kp_q;
    assign err_pulse     = err_q;
    assign pin_changed   = chg_q;
    assign attempts_left = attempts_q;

endmodule

// File: tb/tb_pin_lock_controller.sv
module tb_pin_lock_controller;

    localparam int MAXA = 3;
    localparam int LT   = 20;
    localparam int UT   = 10;

    logic        clk_500Hz = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] userPin = '0;
    logic        validPin = 1'b0;
    logic        lock_req = 1'b0;
    logic        adjust_req = 1'b0;
    logic [1:0]  status;
    logic        kp_enable;
    logic        err_pulse;
    logic        pin_changed;
    logic [3:0]  attempts_left;

    int total = 0;
    int bad = 0;

    pin_lock_controller #(
        .DEFAULT_PIN  (16'h1234),
        .MAX_ATTEMPTS (MAXA),
        .LOCKOUT_TICKS(LT),
        .UNLOCK_TICKS (UT)
    ) dut (
        .clk_500Hz    (clk_500Hz),
        .rst_n        (rst_n),
        .userPin      (userPin),
        .validPin     (validPin),
        .lock_req     (lock_req),
        .adjust_req   (adjust_req),
        .status       (status),
        .kp_enable    (kp_enable),
        .err_pulse    (err_pulse),
        .pin_changed  (pin_changed),
        .attempts_left(attempts_left)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    // Reference model: mode 0 LOCKED, 1 UNLOCKED, 2 ADJUST, 3 LOCKOUT.
    int          m_mode, m_tmr, m_att;
    logic [15:0] m_pin, m_cand;
    bit          m_confirm, m_err, m_chg;

    task automatic m_reset();
        m_mode = 0; m_tmr = 0; m_att = MAXA; m_pin = 16'h1234; m_cand = '0;
        m_confirm = 0; m_err = 0; m_chg = 0;
    endtask

    task automatic m_clock(input logic [15:0] p, input bit v, input bit l, input bit a);
        int prev;
        prev = m_mode;
        m_err = 0;
        m_chg = 0;
        m_tmr++;
        if (m_mode == 0) begin
            if (v && p == m_pin) begin
                m_mode = 1; m_att = MAXA;
            end else if (v) begin
                m_err = 1;
                m_att = m_att - 1;
                if (m_att == 0) begin m_mode = 3; m_att = MAXA; end
            end
        end else if (m_mode == 1) begin
            if (l) m_mode = 0;
            else if (a) begin m_mode = 2; m_confirm = 0; end
            else if (m_tmr == UT) m_mode = 0;
        end else if (m_mode == 2) begin
            if (l) begin m_mode = 0; m_confirm = 0; end
            else if (v) begin
                m_tmr = 0;
                if (!m_confirm) begin m_cand = p; m_confirm = 1; end
                else if (p == m_cand) begin m_pin = m_cand; m_chg = 1; m_mode = 1; m_confirm = 0; end
                else begin m_err = 1; m_confirm = 0; end
            end else if (m_tmr == UT) begin m_mode = 0; m_confirm = 0; end
        end else begin
            if (m_tmr == LT) m_mode = 0;
        end
        if (m_mode != prev || m_mode == 0) m_tmr = 0;
    endtask

    function automatic logic [8:0] outs();
        return {status, kp_enable, err_pulse, pin_changed, attempts_left};
    endfunction

    function automatic logic [8:0] m_outs();
        logic kp;
        kp = (m_mode == 0) || (m_mode == 2);
        return {2'(m_mode), kp, m_err, m_chg, 4'(m_att)};
    endfunction

    task automatic step(input logic [15:0] p, input bit v, input bit l, input bit a);
        userPin = p; validPin = v; lock_req = l; adjust_req = a;
        @(posedge clk_500Hz);
        m_clock(p, v, l, a);
        #1;
        validPin = 1'b0; lock_req = 1'b0; adjust_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_reset();
        #12;
        total++;
        if (outs() !== 9'b00_1_0_0_0011) begin
            bad++; $display("FAIL reset_vals got=%b exp=%b", outs(), 9'b00_1_0_0_0011);
        end
        rst_n = 1'b1;
        @(posedge clk_500Hz); m_clock('0, 0, 0, 0); #1;
    endtask

    task automatic test_unlock();
        userPin = 16'h1234; validPin = 1'b1;
        #1;
        total++;
        if (status !== 2'd0) begin bad++; $display("FAIL unlock_before_edge got=%0d exp=0", status); end
        step(16'h1234, 1, 0, 0);
        total++;
        if (outs() !== {2'd1, 1'b0, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL unlock got=%b exp=%b", outs(), {2'd1, 1'b0, 1'b0, 1'b0, 4'd3});
        end
        step('0, 0, 1, 0);
        total++;
        if (status !== 2'd0) begin bad++; $display("FAIL relock got=%0d exp=0", status); end
    endtask

    task automatic test_lockout();
        for (int i = 1; i <= 2; i++) begin
            step(16'h1111, 1, 0, 0);
            total++;
            if (outs() !== {2'd0, 1'b1, 1'b1, 1'b0, 4'(MAXA - i)}) begin
                bad++; $display("FAIL wrong_pin_%0d got=%b exp=%b", i, outs(), {2'd0, 1'b1, 1'b1, 1'b0, 4'(MAXA - i)});
            end
            step('0, 0, 0, 0);
            total++;
            if (err_pulse !== 1'b0) begin bad++; $display("FAIL err_one_cycle_%0d got=%b exp=0", i, err_pulse); end
        end
        step(16'h1111, 1, 0, 0);
        total++;
        if (outs() !== {2'd3, 1'b0, 1'b1, 1'b0, 4'd3}) begin
            bad++; $display("FAIL enter_lockout got=%b exp=%b", outs(), {2'd3, 1'b0, 1'b1, 1'b0, 4'd3});
        end
        step(16'h1234, 1, 0, 1);
        total++;
        if (outs() !== {2'd3, 1'b0, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL lockout_ignores_pin got=%b exp=%b", outs(), {2'd3, 1'b0, 1'b0, 1'b0, 4'd3});
        end
        for (int k = 2; k <= LT; k++) begin
            step('0, 0, (k == 5), 0);
            total++;
            if (status !== ((k == LT) ? 2'd0 : 2'd3)) begin
                bad++; $display("FAIL lockout_len k=%0d got=%0d exp=%0d", k, status, (k == LT) ? 0 : 3);
            end
        end
    endtask

    task automatic test_autorelock();
        step(16'h1234, 1, 0, 0);
        for (int k = 1; k <= UT; k++) begin
            step('0, 0, 0, 0);
            total++;
            if (status !== ((k == UT) ? 2'd0 : 2'd1)) begin
                bad++; $display("FAIL autorelock k=%0d got=%0d exp=%0d", k, status, (k == UT) ? 0 : 1);
            end
        end
        step(16'h1234, 1, 0, 0);
        step('0, 0, 1, 1);
        total++;
        if (outs() !== {2'd0, 1'b1, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL lock_beats_adjust got=%b exp=%b", outs(), {2'd0, 1'b1, 1'b0, 1'b0, 4'd3});
        end
    endtask

    task automatic test_change_pin();
        step(16'h1234, 1, 0, 0);
        step('0, 0, 0, 1);
        total++;
        if (outs() !== {2'd2, 1'b1, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL enter_adjust got=%b exp=%b", outs(), {2'd2, 1'b1, 1'b0, 1'b0, 4'd3});
        end
        step(16'h5678, 1, 0, 0);
        step(16'h5678, 1, 0, 0);
        total++;
        if (outs() !== {2'd1, 1'b0, 1'b0, 1'b1, 4'd3}) begin
            bad++; $display("FAIL pin_commit got=%b exp=%b", outs(), {2'd1, 1'b0, 1'b0, 1'b1, 4'd3});
        end
        step('0, 0, 0, 0);
        total++;
        if (pin_changed !== 1'b0) begin bad++; $display("FAIL chg_one_cycle got=%b exp=0", pin_changed); end
        step('0, 0, 1, 0);
        step(16'h1234, 1, 0, 0);
        total++;
        if (outs() !== {2'd0, 1'b1, 1'b1, 1'b0, 4'd2}) begin
            bad++; $display("FAIL old_pin_rejected got=%b exp=%b", outs(), {2'd0, 1'b1, 1'b1, 1'b0, 4'd2});
        end
        step(16'h5678, 1, 0, 0);
        total++;
        if (outs() !== {2'd1, 1'b0, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL new_pin_unlocks got=%b exp=%b", outs(), {2'd1, 1'b0, 1'b0, 1'b0, 4'd3});
        end
        step('0, 0, 1, 0);
    endtask

    task automatic test_async_reset();
        step(16'h5678, 1, 0, 0);
        step('0, 0, 0, 1);
        step(16'h1111, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        total++;
        if (outs() !== {2'd0, 1'b1, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL async_reset got=%b exp=%b", outs(), {2'd0, 1'b1, 1'b0, 1'b0, 4'd3});
        end
        #2;
        rst_n = 1'b1;
        step(16'h1234, 1, 0, 0);
        total++;
        if (status !== 2'd1) begin bad++; $display("FAIL default_pin_restored got=%0d exp=1", status); end
        step('0, 0, 1, 0);
    endtask

    task automatic test_confirm_fail();
        step(16'h1234, 1, 0, 0);
        step('0, 0, 0, 1);
        step(16'h5678, 1, 0, 0);
        step(16'h5679, 1, 0, 0);
        total++;
        if (outs() !== {2'd2, 1'b1, 1'b1, 1'b0, 4'd3}) begin
            bad++; $display("FAIL confirm_mismatch got=%b exp=%b", outs(), {2'd2, 1'b1, 1'b1, 1'b0, 4'd3});
        end
        // Back in NEW: this entry becomes a candidate, not a failed confirm.
        step(16'h5679, 1, 0, 0);
        total++;
        if (outs() !== {2'd2, 1'b1, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL back_to_new got=%b exp=%b", outs(), {2'd2, 1'b1, 1'b0, 1'b0, 4'd3});
        end
        step(16'h5679, 1, 1, 0);
        total++;
        if (outs() !== {2'd0, 1'b1, 1'b0, 1'b0, 4'd3}) begin
            bad++; $display("FAIL lock_beats_confirm got=%b exp=%b", outs(), {2'd0, 1'b1, 1'b0, 1'b0, 4'd3});
        end
        step(16'h1234, 1, 0, 0);
        total++;
        if (status !== 2'd1) begin bad++; $display("FAIL pin_unchanged got=%0d exp=1", status); end
        step('0, 0, 1, 0);
    endtask

    task automatic test_random();
        logic [15:0] p;
        bit v, l, a;
        int sel;
        for (int c = 0; c < 2000; c++) begin
            sel = $urandom_range(0, 3);
            p = (sel == 0) ? m_pin : (sel == 1) ? m_cand : (sel == 2) ? 16'h1234 : 16'($urandom);
            v = ($urandom_range(0, 99) < 40);
            l = ($urandom_range(0, 99) < 4);
            a = ($urandom_range(0, 99) < 12);
            step(p, v, l, a);
            total++;
            if (outs() !== m_outs()) begin
                bad++; $display("FAIL random c=%0d got=%b exp=%b", c, outs(), m_outs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_autorelock();
        test_change_pin();
        test_async_reset();
        test_confirm_fail();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
